seg_bcd_seq: RTL and testbench
==============================

# seg_bcd_seq

Sequential binary-to-BCD converter that sits directly upstream of the hex seven-segment scanner. It replaces the combinational divide/modulo BCD path with a shift-and-add-3 (double-dabble) engine. The engine accepts a 24-bit binary value on a start strobe and produces six packed BCD digits, ready for the hex scanner's `iNum`. The result is held stable between conversions, so the multiplexed display never shows partial values.

## Interface
Parameters:
- `WIDTH`, 24: binary input width.
- `DIGITS`, 6: number of BCD output digits; output width is 4*DIGITS.

Ports:
- `iCLK`  in  1  clock. Single clock domain.
- `iRST`  in  1  reset. Synchronous, active-high.
- `iNum`  in  24  binary value to convert. Sampled only on an accepted start.
- `iStart`  in  1  conversion request. Accepted only while idle.
- `oBcd`  out  24  packed BCD result. Digit 0 is `[3:0]` (units), digit 5 is `[23:20]`.
- `oValid`  out  1  one-cycle pulse when `oBcd` has just been updated.
- `oBusy`  out  1  high while a conversion is in progress.
- `oOvf`  out  1  result flag: the converted input exceeded 999999. Updated together with `oBcd`.

## Operation
- FSM states: IDLE, SHIFT.
- IDLE → SHIFT when `iStart`=1 at a clock edge.
  - On that edge, `iNum` is latched into the binary shift register.
  - The BCD working register is cleared.
  - The iteration counter is set to 0.
  - `oBusy` goes to 1.
  - The overflow compare (`iNum` > 24'd999999) is latched into a pending flag.
- Each SHIFT edge performs one iteration:
  - Every BCD working digit ≥ 5 gets +3. This is combinational and applied before the shift.
  - The {BCD, binary} register is shifted left by 1.
  - The counter is incremented.
- There are exactly 24 iterations (counter 0..23).
- On the edge that performs iteration 23:
  - `oBcd` is loaded with the post-shift BCD value.
  - `oOvf` is loaded with the pending flag.
  - `oValid` is set to 1 and `oBusy` to 0.
  - The state returns to IDLE.
- The carry out of digit 5 is discarded. The result is therefore `iNum` mod 1000000, with `oOvf` marking that truncation.
- Every working digit must stay in 0..9 after each iteration.
- `iStart` while busy is ignored and is not queued.
- `iStart` held high continuously causes back-to-back conversions, one every 25 cycles.
- `oBcd` and `oOvf` hold their last values until the next completion. They do not change during SHIFT.
- Reset:
  - `oBcd`=0, `oValid`=0, `oBusy`=0, `oOvf`=0, state=IDLE.
  - The working registers and counter are cleared.
  - A reset during SHIFT aborts the conversion. No `oValid` is produced, and `oBcd` reads 0 on the next cycle.
  - If `iRST` and `iStart` are high on the same edge, reset wins and no conversion starts.

## Timing
- Start accepted at edge N.
  - `oBusy`=1 from after edge N through edge N+24.
  - Iterations happen on edges N+1..N+24.
- `oBcd`, `oOvf` and `oValid` update at edge N+24. `oValid` is high for exactly the cycle between edges N+24 and N+25.
- Latency is 24 cycles from the accepting edge to valid result. The next start can be accepted at edge N+25, giving 25-cycle throughput.
- `oValid` and `oBusy` are never high in the same cycle.
- `oBusy` is low in the `oValid` cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- One iteration's critical path is six parallel 4-bit compare/add-3 units plus a shift. It must close at the design's 120 MHz system clock.

## Test plan
- Reset, then `iNum`=24'd123456 with a 1-cycle `iStart`.
  - `oBusy` is high for 24 cycles.
  - Then `oValid` pulses for 1 cycle with `oBcd`=24'h123456 and `oOvf`=0.
- `iNum`=0 → `oBcd`=24'h000000, `oOvf`=0.
- `iNum`=999999 → `oBcd`=24'h999999, `oOvf`=0.
- `iNum`=1000000 → `oBcd`=24'h000000, `oOvf`=1.
- `iNum`=16777215 → `oBcd`=24'h777215, `oOvf`=1.
- Start with 42, then pulse `iStart` with `iNum`=7 at cycles +5 and +24.
  - Both pulses are ignored.
  - The single `oValid` carries `oBcd`=24'h000042.
  - `iStart` at +25 is accepted, and 25 cycles later `oBcd`=24'h000007.
- Start with 555555, then assert `iRST` at iteration 10.
  - No `oValid` pulse occurs.
  - `oBcd`=0 and `oBusy`=0 on the next cycle.
  - A following start with 31 yields 24'h000031 after 24 cycles.
- `iStart` tied high with `iNum` swept randomly over 0..16777215.
  - `oValid` pulses every 25 cycles.
  - Each result matches a reference mod-10^6 BCD model plus the overflow flag.

Source files
------------

// File: rtl/seg_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3) feeding the hex scanner.
// One iteration per clock; result and overflow flag are held between conversions.
module seg_bcd_seq #(
  parameter int WIDTH  = 24,
  parameter int DIGITS = 6
) (
  input  logic                  iCLK,
  input  logic                  iRST,
  input  logic [WIDTH-1:0]      iNum,
  input  logic                  iStart,
  output logic [4*DIGITS-1:0]   oBcd,
  output logic                  oValid,
  output logic                  oBusy,
  output logic                  oOvf
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH);
  localparam logic [63:0] MaxVal = 64'(10 ** DIGITS) - 64'd1;

  typedef enum logic {IDLE, SHIFT} stateT;

  stateT            state, stateNext;
  logic [WIDTH-1:0] binReg;
  logic [BW-1:0]    bcdReg, bcdAdj, bcdNext;
  logic [CW-1:0]    cnt;
  logic             pendOvf;
  logic             load, step, last;

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    stateNext = state;
    load      = 1'b0;
    step      = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        if (iStart) begin
          load      = 1'b1;
          stateNext = SHIFT;
        end
      end
      SHIFT: begin
        step = 1'b1;
        if (cnt == CW'(WIDTH - 1)) begin
          last      = 1'b1;
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge iCLK) begin
    if (iRST) state <= IDLE;
    else      state <= stateNext;
  end

  // Digits >= 5 get +3 before the shift so that doubling carries correctly into the next digit.
  always_comb begin
    bcdAdj = bcdReg;
    for (int d = 0; d < DIGITS; d++) begin
      if (bcdReg[4*d +: 4] >= 4'd5) bcdAdj[4*d +: 4] = bcdReg[4*d +: 4] + 4'd3;
    end
  end

  // The carry out of the top digit drops off here, giving the result modulo 10^DIGITS.
  assign bcdNext = {bcdAdj[BW-2:0], binReg[WIDTH-1]};

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      binReg  <= '0;
      bcdReg  <= '0;
      cnt     <= '0;
      pendOvf <= 1'b0;
      oBcd    <= '0;
      oOvf    <= 1'b0;
      oValid  <= 1'b0;
    end else begin
      oValid <= 1'b0;
      if (load) begin
        binReg  <= iNum;
        bcdReg  <= '0;
        cnt     <= '0;
        pendOvf <= 64'(iNum) > MaxVal;
      end else if (step) begin
        binReg <= binReg << 1;
        bcdReg <= bcdNext;
        cnt    <= cnt + CW'(1);
        if (last) begin
          oBcd   <= bcdNext;
          oOvf   <= pendOvf;
          oValid <= 1'b1;
        end
      end
    end
  end

  assign oBusy = (state == SHIFT);

endmodule

// File: tb/tb_seg_bcd_seq.sv
// Self-checking bench for seg_bcd_seq: cycle model of busy/valid timing plus a
// result scoreboard filled on accepted starts and drained on each oValid.
module tb_seg_bcd_seq;

  logic        iCLK = 1'b0;
  logic        iRST;
  logic [23:0] iNum;
  logic        iStart;
  logic [23:0] oBcd;
  logic        oValid;
  logic        oBusy;
  logic        oOvf;

  seg_bcd_seq #(.WIDTH(24), .DIGITS(6)) dut (
    .iCLK  (iCLK),
    .iRST  (iRST),
    .iNum  (iNum),
    .iStart(iStart),
    .oBcd  (oBcd),
    .oValid(oValid),
    .oBusy (oBusy),
    .oOvf  (oOvf)
  );

  always #5 iCLK = ~iCLK;

  typedef struct packed {
    logic [23:0] bcd;
    logic        ovf;
  } resultT;

  typedef struct {
    logic [23:0] num;
    logic [23:0] bcd;
    logic        ovf;
  } vecT;

  int     checks   = 0;
  int     failures = 0;
  int     mCnt     = 0;      // iterations still outstanding in the model
  logic   expValid = 1'b0;
  resultT hold     = '0;     // value oBcd/oOvf must currently show
  resultT pendExp  = '0;     // expected result for the value now on iNum
  resultT q[$];
  vecT    vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic resultT refConv(input logic [23:0] n);
    int unsigned v;
    resultT      r;
    v     = int'(n) % 1000000;
    r.bcd = '0;
    for (int d = 0; d < 6; d++) begin
      r.bcd[4*d +: 4] = 4'(v % 10);
      v = v / 10;
    end
    r.ovf = (n > 24'd999999);
    return r;
  endfunction

  task automatic setNum(input logic [23:0] n);
    iNum    = n;
    pendExp = refConv(n);
  endtask

  // One clock edge: advance the model, then compare every output #1 after the edge.
  task automatic step();
    logic   rst, acc;
    resultT exp;
    rst = iRST;
    acc = !iRST && iStart && (mCnt == 0);
    exp = pendExp;
    @(posedge iCLK);
    #1;
    expValid = 1'b0;
    if (rst) begin
      q.delete();
      mCnt = 0;
      hold = '0;
    end else if (acc) begin
      mCnt = 24;
      q.push_back(exp);
    end else if (mCnt > 0) begin
      mCnt--;
      expValid = (mCnt == 0);
    end
    if (oValid && q.size() > 0) hold = q.pop_front();
    check("valid", 32'(oValid), 32'(expValid));
    check("busy",  32'(oBusy),  32'(mCnt > 0));
    check("bcd",   32'(oBcd),   32'(hold.bcd));
    check("ovf",   32'(oOvf),   32'(hold.ovf));
  endtask

  task automatic runSteps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    vecs[0] = '{24'd123456,   24'h123456, 1'b0};
    vecs[1] = '{24'd0,        24'h000000, 1'b0};
    vecs[2] = '{24'd999999,   24'h999999, 1'b0};
    vecs[3] = '{24'd1000000,  24'h000000, 1'b1};
    vecs[4] = '{24'd16777215, 24'h777215, 1'b1};
    vecs[5] = '{24'd9,        24'h000009, 1'b0};
    vecs[6] = '{24'd505050,   24'h505050, 1'b0};

    iRST   = 1'b1;
    iStart = 1'b0;
    setNum(24'd0);
    runSteps(2);
    iRST = 1'b0;
    runSteps(2);

    // Directed values, each a single-cycle start followed by a full conversion.
    foreach (vecs[k]) begin
      iNum    = vecs[k].num;
      pendExp = '{vecs[k].bcd, vecs[k].ovf};
      iStart  = 1'b1;
      step();
      iStart = 1'b0;
      runSteps(27);
      check("tbl_drain", 32'(q.size()), 32'd0);
    end

    // Starts at +5 and +24 must be ignored; the one at +25 is accepted.
    setNum(24'd42);
    iStart = 1'b1;
    step();
    iStart = 1'b0;
    setNum(24'd7);
    runSteps(4);
    iStart = 1'b1;
    step();
    iStart = 1'b0;
    runSteps(18);
    iStart = 1'b1;
    step();
    check("ign_result", 32'(oBcd), 32'h000042);
    step();
    iStart = 1'b0;
    check("ign_busy_restart", 32'(oBusy), 32'd1);
    runSteps(25);
    check("restart_result", 32'(oBcd), 32'h000007);
    check("ign_drain", 32'(q.size()), 32'd0);

    // Reset lands on the edge that would perform iteration 10.
    setNum(24'd555555);
    iStart = 1'b1;
    step();
    iStart = 1'b0;
    runSteps(10);
    iRST = 1'b1;
    step();
    iRST = 1'b0;
    check("abort_bcd",  32'(oBcd),  32'd0);
    check("abort_busy", 32'(oBusy), 32'd0);
    runSteps(30);
    setNum(24'd31);
    iStart = 1'b1;
    step();
    iStart = 1'b0;
    runSteps(24);
    check("after_abort", 32'(oBcd), 32'h000031);
    runSteps(2);

    // Reset and start on the same edge: reset wins.
    iRST   = 1'b1;
    iStart = 1'b1;
    step();
    iRST   = 1'b0;
    iStart = 1'b0;
    check("rst_wins_busy", 32'(oBusy), 32'd0);
    runSteps(3);

    // Start tied high with a fresh random value every cycle.
    iStart = 1'b1;
    for (int i = 0; i < 250; i++) begin
      setNum(24'($urandom_range(0, 24'hFFFFFF)));
      step();
    end
    iStart = 1'b0;
    runSteps(27);
    check("sweep_drain", 32'(q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
